mips_instr_encoder_loader: RTL
==============================

Name: mips_instr_encoder_loader

Overview:
Encodes symbolic instruction requests (operation class plus register and immediate fields) into 32-bit MIPS instruction words. Writes the words sequentially into instruction memory, so it acts as the encoder counterpart of the opcode decoder in the control path. It is used by the testbench/boot loader to fill IMEM before the pipeline runs. Input uses a valid/ready handshake; output is a one-cycle-latency IMEM write port with an auto-incrementing word address.

Parameters:
ADDR_W, 8, IMEM word-address width
DEPTH, 256, number of IMEM words writable (must be at most 2**ADDR_W)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: clear address/count, begin a load session
finish  in  1  one-cycle pulse: end session after any pending write
in_valid  in  1  request valid
in_ready  out  1  request can be accepted this cycle
in_op  in  4  operation class (see package enum)
in_rs  in  5  source register rs
in_rt  in  5  source/destination register rt
in_rd  in  5  destination register rd (R-type only)
in_imm  in  16  immediate / offset (I-type only)
imem_we  out  1  IMEM write strobe
imem_addr  out  ADDR_W  IMEM word address
imem_wdata  out  32  encoded instruction
count  out  ADDR_W+1  words written this session
full  out  1  count == DEPTH
err_illegal  out  1  sticky: an undefined in_op was presented
done  out  1  session complete

Behaviour:
- Reset values: every output is 0. State = IDLE, address = 0, count = 0, pending = 0.
- States:
  - IDLE → LOAD on start.
  - LOAD → FLUSH on finish while pending = 1.
  - LOAD → DONE on finish while pending = 0.
  - FLUSH → DONE after the pending write issues.
  - DONE → LOAD on start. done = 1 only while in DONE.
- start in any state except IDLE/DONE is ignored. In IDLE/DONE, start clears address, count, err_illegal and done.
- in_ready = (state == LOAD) && !full && !finish.
- Accept occurs when in_valid && in_ready. On accept of a legal op:
  - Register the encoded word; set pending.
  - Next cycle: imem_we = 1, imem_addr = current address, imem_wdata = word. Then address++, count++.
  - Latency is exactly 1 cycle. Back-to-back accepts give a write every cycle.
- R-type encoding: {6'b000000, rs, rt, rd, 5'b00000, funct}. Functs: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
- I-type encoding: {opcode, rs, rt, imm}. Opcodes: LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010.
- Illegal in_op (values 12–15): the request is accepted (handshake completes) but nothing is written. err_illegal is set; count and address are unchanged.
- full: when count reaches DEPTH, in_ready drops and no further writes occur. address never wraps within a session.
- finish in the same cycle as in_valid: in_ready is 0, so the request is not accepted; the session ends.
- imem_we is never asserted outside the cycle after a legal accept.
- reset mid-session: immediate return to IDLE, any pending write is dropped, all outputs are 0.

Decomposition:
- Shared package mips_isa_pkg holds:
  - 6-bit opcode constants (R_TYPE, LW, SW, BEQ, ADDI, ANDI, ORI, SLTI), also used by the control decoder.
  - funct constants.
  - 4-bit op-class enum: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LW=5, SW=6, BEQ=7, ADDI=8, ANDI=9, ORI=10, SLTI=11.
  - FSM state encoding.
- One combinational sub-module, mips_instr_encode: in_op/rs/rt/rd/imm → {word[31:0], legal}. The top level holds the FSM, handshake, address/count and output register.

Test Plan:
- reset; start; ADDI rs=1 rt=2 imm=0x0005 → 1 cycle later imem_we=1, addr=0, wdata=0x20220005; count=1.
- Back-to-back ADD rs=1 rt=2 rd=3, then LW rs=0 rt=4 imm=0x0010 → writes 0x00221820 @0 then 0x8C040010 @1 on consecutive cycles.
- in_op=13 between two legal ops → err_illegal=1, no write, next legal op lands at addr 1, count=2.
- DEPTH=4, present 6 ops → exactly 4 writes (addr 0–3), full=1, in_ready=0 for ops 5–6.
- accept BEQ rs=1 rt=2 imm=0xFFFF, finish next cycle → write 0x1022FFFF issues, FLUSH, then done=1; start → done=0, count=0.
- reset asserted asynchronously mid-stream with a pending word → imem_we=0 immediately, count=0, state IDLE, in_ready=0.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the instruction encoder/loader and the control decoder.
// Holds opcodes, functs, the symbolic op-class enum and the loader FSM states.
package mips_isa_pkg;

    localparam logic [5:0] OPC_R_TYPE = 6'b000000;
    localparam logic [5:0] OPC_LW     = 6'b100011;
    localparam logic [5:0] OPC_SW     = 6'b101011;
    localparam logic [5:0] OPC_BEQ    = 6'b000100;
    localparam logic [5:0] OPC_ADDI   = 6'b001000;
    localparam logic [5:0] OPC_ANDI   = 6'b001100;
    localparam logic [5:0] OPC_ORI    = 6'b001101;
    localparam logic [5:0] OPC_SLTI   = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_ADDI = 4'd8,
        OP_ANDI = 4'd9,
        OP_ORI  = 4'd10,
        OP_SLTI = 4'd11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } state_e;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OPC_R_TYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_encode.sv
// Combinational encoder: symbolic op class plus register/immediate fields to a MIPS word.
// Op classes 12-15 are undefined and reported through legal_o.
module mips_instr_encode
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [15:0] imm_i,
    output logic [31:0] word_o,
    output logic        legal_o
);

    always_comb begin
        word_o  = '0;
        legal_o = 1'b1;
        case (op_i)
            OP_ADD:  word_o = enc_r(rs_i, rt_i, rd_i, FN_ADD);
            OP_SUB:  word_o = enc_r(rs_i, rt_i, rd_i, FN_SUB);
            OP_AND:  word_o = enc_r(rs_i, rt_i, rd_i, FN_AND);
            OP_OR:   word_o = enc_r(rs_i, rt_i, rd_i, FN_OR);
            OP_SLT:  word_o = enc_r(rs_i, rt_i, rd_i, FN_SLT);
            OP_LW:   word_o = enc_i(OPC_LW,   rs_i, rt_i, imm_i);
            OP_SW:   word_o = enc_i(OPC_SW,   rs_i, rt_i, imm_i);
            OP_BEQ:  word_o = enc_i(OPC_BEQ,  rs_i, rt_i, imm_i);
            OP_ADDI: word_o = enc_i(OPC_ADDI, rs_i, rt_i, imm_i);
            OP_ANDI: word_o = enc_i(OPC_ANDI, rs_i, rt_i, imm_i);
            OP_ORI:  word_o = enc_i(OPC_ORI,  rs_i, rt_i, imm_i);
            OP_SLTI: word_o = enc_i(OPC_SLTI, rs_i, rt_i, imm_i);
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder_loader.sv
// Boot-time IMEM loader: accepts symbolic instruction requests over valid/ready and
// writes the encoded words to sequential IMEM addresses with one cycle of latency.
module mips_instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err_illegal,
    output logic              done
);

    state_e              state_q;
    logic [ADDR_W:0]     count_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [31:0]         imem_wdata_q;
    logic                err_q;
    logic                done_q;

    logic [31:0]         enc_word;
    logic                enc_legal;
    logic                accept;

    mips_instr_encode u_encode (
        .op_i    (in_op),
        .rs_i    (in_rs),
        .rt_i    (in_rt),
        .rd_i    (in_rd),
        .imm_i   (in_imm),
        .word_o  (enc_word),
        .legal_o (enc_legal)
    );

    assign full     = (count_q == (ADDR_W + 1)'(DEPTH));
    assign in_ready = (state_q == ST_LOAD) && !full && !finish;
    assign accept   = in_valid && in_ready;

    // Illegal ops never advance the count, so count doubles as the next write address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_LOAD;
                        count_q <= '0;
                        err_q   <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // imem_we_q high here means a write is still on the port (pending).
                    if (finish) begin
                        if (imem_we_q) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end else if (accept) begin
                        if (enc_legal) begin
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= count_q[ADDR_W-1:0];
                            imem_wdata_q <= enc_word;
                            count_q      <= count_q + 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_FLUSH: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign count       = count_q;
    assign err_illegal = err_q;
    assign done        = done_q;

endmodule
